mem_port_arbiter: RTL and testbench

Shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch port (IF) and data port (MEM stage lw/sw).
- Serialises transactions with a small FSM.
- Data port has priority by default; a starvation guard bounds how long IF can be blocked.
- Produces per-port stall outputs that feed the pipeline's global stall logic.
- Handles IF flush by discarding an in-flight fetch result.

---
 rtl/mem_port_arbiter_pkg.sv | 26 ++
 rtl/arb_starve_counter.sv | 37 +++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/MEM unified-memory arbiter.
// Imported by the arbiter top and its starvation counter.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Data wins ties unless IF has already been passed over STARVE_MAX times.
  function automatic logic pick_port(input logic i_elig, input logic d_elig,
                                     input logic at_max);
    if (d_elig && !(i_elig && at_max)) return PORT_D;
    return PORT_I;
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of data grants issued while IF was waiting.
// Clear has priority over increment.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                inc,
  output logic [STARVE_W-1:0] cnt,
  output logic                at_max
);

  localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(MAX);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt    = cnt_q;
  assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and MEM-stage loads/stores onto one single-port memory.
// Data has priority; a starvation counter forces IF through after STARVE_MAX data grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_kill,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                if_stall,
  output logic                mem_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  arb_state_t          state_q, state_d;
  logic                kill_pend_q, kill_pend_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                i_ack_q, i_ack_d;
  logic                d_ack_q, d_ack_d;

  logic                i_elig, d_elig;
  logic                grant_i, grant_d;
  logic                starve_clr, starve_inc, starve_at_max;
  logic [STARVE_W-1:0] starve_cnt;

  assign i_elig = i_req & ~i_ack_q & ~i_kill;
  assign d_elig = d_req & ~d_ack_q;

  always_comb begin
    state_d     = state_q;
    kill_pend_d = kill_pend_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    grant_i     = 1'b0;
    grant_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_elig || d_elig) begin
          if (pick_port(i_elig, d_elig, starve_at_max) == PORT_D) grant_d = 1'b1;
          else                                                    grant_i = 1'b1;
        end
        if (grant_d) begin
          state_d     = BUSY_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_wstrb;
        end else if (grant_i) begin
          state_d     = BUSY_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
        end
      end
      BUSY_I: begin
        if (i_kill) kill_pend_d = 1'b1;
        if (mem_ready) begin
          state_d     = IDLE;
          mem_req_d   = 1'b0;
          kill_pend_d = 1'b0;
          // A flushed fetch still drains from memory but its result is dropped.
          if (!(kill_pend_q || i_kill)) begin
            i_ack_d   = 1'b1;
            i_rdata_d = mem_rdata;
          end
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_ack_d   = 1'b1;
          if (!mem_we_q) d_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign starve_clr = grant_i | ~i_req;
  assign starve_inc = grant_d & i_req & ~i_kill;

  arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .reset  (reset),
    .clr    (starve_clr),
    .inc    (starve_inc),
    .cnt    (starve_cnt),
    .at_max (starve_at_max)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      kill_pend_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      kill_pend_q <= kill_pend_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ack_q     <= i_ack_d;
      d_ack_q     <= d_ack_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign if_stall  = i_req & ~i_ack_q;
  assign mem_stall = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a variable-latency memory model.
// Expected values are hand-computed per scenario.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0, i_kill = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [3:0]  d_wstrb = '0;
  logic [31:0] d_rdata;
  logic        d_ack, if_stall, mem_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int          n_chk = 0;
  int          n_err = 0;
  int          mem_lat = 2;
  int          lat_cnt;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic [3:0]  wr_strb = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ack(d_ack), .if_stall(if_stall), .mem_stall(mem_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h13;
      32'h100: return 32'h64;
      32'h40:  return 32'h93;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Memory: mem_ready pulses mem_lat cycles after mem_req is first seen.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    lat_cnt   = 0;
    forever begin
      @(posedge clk); #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        lat_cnt   = 0;
      end else if (mem_req) begin
        lat_cnt++;
        if (lat_cnt >= mem_lat) begin
          mem_ready = 1'b1;
          mem_rdata = mem_val(mem_addr);
          if (mem_we) begin
            wr_addr = mem_addr;
            wr_data = mem_wdata;
            wr_strb = mem_wstrb;
          end
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_i_ack(input string tag, output int n);
    n = 0;
    do begin tick(); n++; end while (!i_ack && n < 30);
    check({tag, "_i_ack_seen"}, {31'd0, i_ack}, 32'd1);
  endtask

  task automatic wait_d_ack(input string tag, output int n);
    n = 0;
    do begin tick(); n++; end while (!d_ack && n < 30);
    check({tag, "_d_ack_seen"}, {31'd0, d_ack}, 32'd1);
  endtask

  initial begin
    int   n;
    int   g;
    logic prev_req;
    logic stable;
    logic exp_port [6];
    logic got_port;

    // Reset state
    #3;
    check("rst_i_ack",   {31'd0, i_ack},   32'd0);
    check("rst_d_ack",   {31'd0, d_ack},   32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we",  {31'd0, mem_we},  32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_i_rdata",  i_rdata,  32'd0);
    check("rst_d_rdata",  d_rdata,  32'd0);
    #9 reset = 1'b1;
    tick();

    // Single fetch, 2-cycle memory
    mem_lat = 2;
    i_req = 1'b1; i_addr = 32'h10;
    #1 check("f1_if_stall", {31'd0, if_stall}, 32'd1);
    tick();
    check("f1_mem_req",  {31'd0, mem_req}, 32'd1);
    check("f1_mem_addr", mem_addr, 32'h10);
    check("f1_mem_we",   {31'd0, mem_we}, 32'd0);
    n = 1;
    while (!i_ack && n < 30) begin
      check("f1_stall_wait", {31'd0, if_stall}, 32'd1);
      tick(); n++;
    end
    check("f1_latency", n, 32'd3);
    check("f1_i_rdata", i_rdata, 32'h13);
    check("f1_if_stall_ack", {31'd0, if_stall}, 32'd0);
    i_req = 1'b0;
    tick();
    check("f1_ack_pulse", {31'd0, i_ack}, 32'd0);

    // Simultaneous IF + load: D first, IF in the d_ack cycle
    mem_lat = 1;
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    tick();
    check("sim_d_addr", mem_addr, 32'h100);
    check("sim_starve1", {28'd0, u_dut.u_starve.cnt_q}, 32'd1);
    wait_d_ack("sim", n);
    check("sim_d_rdata", d_rdata, 32'h64);
    d_req = 1'b0;
    tick();
    check("sim_i_grant", {31'd0, mem_req}, 32'd1);
    check("sim_i_addr", mem_addr, 32'h10);
    check("sim_starve0", {28'd0, u_dut.u_starve.cnt_q}, 32'd0);
    wait_i_ack("sim", n);
    check("sim_i_rdata", i_rdata, 32'h13);
    i_req = 1'b0;
    tick();

    // Starvation: IF killed in each d_ack cycle, so only the guard lets it in
    exp_port = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_addr = 32'h100;
    prev_req = 1'b0; g = 0; n = 0;
    while (g < 6 && n < 80) begin
      tick(); n++;
      i_kill = d_ack;
      if (mem_req && !prev_req) begin
        got_port = (mem_addr == 32'h100);
        check($sformatf("starve_grant%0d", g), {31'd0, got_port}, {31'd0, exp_port[g]});
        g++;
      end
      prev_req = mem_req;
    end
    check("starve_ngrants", g, 32'd6);
    i_req = 1'b0; d_req = 1'b0; i_kill = 1'b0;
    repeat (4) tick();

    // Store: registered values stable until completion, d_rdata untouched
    mem_lat = 3;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    tick();
    check("st_mem_we",    {31'd0, mem_we}, 32'd1);
    check("st_mem_addr",  mem_addr,  32'h200);
    check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("st_mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
    d_addr = 32'h300; d_wdata = 32'h0; d_we = 1'b0;
    stable = 1'b1; n = 0;
    while (!d_ack && n < 30) begin
      if (mem_req && !(mem_we && mem_addr == 32'h200 && mem_wdata == 32'hDEAD_BEEF))
        stable = 1'b0;
      tick(); n++;
    end
    check("st_stable", {31'd0, stable}, 32'd1);
    check("st_d_ack", {31'd0, d_ack}, 32'd1);
    check("st_d_rdata_kept", d_rdata, 32'h64);
    check("st_wr_addr", wr_addr, 32'h200);
    check("st_wr_data", wr_data, 32'hDEAD_BEEF);
    check("st_wr_strb", {28'd0, wr_strb}, 32'hF);
    d_req = 1'b0;
    tick();

    // Flush during a 3-cycle fetch; refetch of 0x40 then acks
    i_req = 1'b1; i_addr = 32'h30;
    tick();
    check("fl_mem_addr", mem_addr, 32'h30);
    i_kill = 1'b1; i_addr = 32'h40;
    tick();
    i_kill = 1'b0;
    n = 0;
    while (mem_req && !i_ack && n < 30) begin tick(); n++; end
    check("fl_done", {31'd0, mem_req}, 32'd0);
    check("fl_no_ack", {31'd0, i_ack}, 32'd0);
    check("fl_rdata_kept", i_rdata, 32'h13);
    wait_i_ack("fl", n);
    check("fl_new_rdata", i_rdata, 32'h93);
    check("fl_new_addr", mem_addr, 32'h40);
    i_req = 1'b0;
    tick();

    // Async reset in the middle of a data transaction
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    tick();
    check("rb_mem_req", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rb_mem_req_drop", {31'd0, mem_req}, 32'd0);
    check("rb_d_ack", {31'd0, d_ack}, 32'd0);
    check("rb_i_ack", {31'd0, i_ack}, 32'd0);
    check("rb_d_rdata", d_rdata, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check("rb_state_idle", {30'd0, u_dut.state_q}, 32'd0);
    wait_d_ack("rb", n);
    check("rb_d_rdata_after", d_rdata, 32'h64);
    d_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
